// File: rtl/axi4lite_pkg.sv
// Shared AXI4-Lite definitions: response codes, master FSM states, default PROT.
package axi4lite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [2:0] PROT_DEFAULT = 3'b000;

  typedef enum logic [2:0] {
    IDLE,
    WR_REQ,
    WR_RESP,
    RD_REQ,
    RD_DATA,
    RSP
  } state_e;

endpackage

// File: rtl/axi4lite_master.sv
// Single-outstanding AXI4-Lite master: turns one command into one AXI
// read or write transaction and returns one response.
module axi4lite_master
  import axi4lite_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  // command
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0] cmd_wstrb,
  // response
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic                    rsp_write,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic [1:0]              rsp_resp,
  // AXI write address
  output logic [ADDR_WIDTH-1:0]   m_awaddr,
  output logic [2:0]              m_awprot,
  output logic                    m_awvalid,
  input  logic                    m_awready,
  // AXI write data
  output logic [DATA_WIDTH-1:0]   m_wdata,
  output logic [DATA_WIDTH/8-1:0] m_wstrb,
  output logic                    m_wvalid,
  input  logic                    m_wready,
  // AXI write response
  input  logic [1:0]              m_bresp,
  input  logic                    m_bvalid,
  output logic                    m_bready,
  // AXI read address
  output logic [ADDR_WIDTH-1:0]   m_araddr,
  output logic [2:0]              m_arprot,
  output logic                    m_arvalid,
  input  logic                    m_arready,
  // AXI read data
  input  logic [DATA_WIDTH-1:0]   m_rdata,
  input  logic [1:0]              m_rresp,
  input  logic                    m_rvalid,
  output logic                    m_rready
);

  state_e                  state_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [DATA_WIDTH/8-1:0] wstrb_q;
  logic                    awvalid_q, wvalid_q, arvalid_q, bready_q, rready_q;
  logic                    aw_done_q, w_done_q;
  logic                    rsp_valid_q, rsp_write_q;
  logic [DATA_WIDTH-1:0]   rsp_rdata_q;
  logic [1:0]              rsp_resp_q;

  logic aw_hs, w_hs, aw_done_d, w_done_d;

  assign aw_hs     = awvalid_q && m_awready;
  assign w_hs      = wvalid_q && m_wready;
  assign aw_done_d = aw_done_q || aw_hs;
  assign w_done_d  = w_done_q || w_hs;

  // Gated by rst so it reads 0 throughout reset and 1 as soon as reset drops.
  assign cmd_ready = (state_q == IDLE) && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      bready_q    <= 1'b0;
      rready_q    <= 1'b0;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_write_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_resp_q  <= RESP_OKAY;
    end else begin
      case (state_q)
        IDLE: begin
          if (cmd_valid) begin
            addr_q  <= cmd_addr;
            wdata_q <= cmd_wdata;
            wstrb_q <= cmd_wstrb;
            if (cmd_write) begin
              state_q   <= WR_REQ;
              awvalid_q <= 1'b1;
              wvalid_q  <= 1'b1;
              aw_done_q <= 1'b0;
              w_done_q  <= 1'b0;
            end else begin
              state_q   <= RD_REQ;
              arvalid_q <= 1'b1;
            end
          end
        end
        WR_REQ: begin
          // AW and W complete independently, in either order or together.
          if (aw_hs) awvalid_q <= 1'b0;
          if (w_hs)  wvalid_q  <= 1'b0;
          aw_done_q <= aw_done_d;
          w_done_q  <= w_done_d;
          if (aw_done_d && w_done_d) begin
            state_q  <= WR_RESP;
            bready_q <= 1'b1;
          end
        end
        WR_RESP: begin
          if (m_bvalid && bready_q) begin
            state_q     <= RSP;
            bready_q    <= 1'b0;
            rsp_resp_q  <= m_bresp;
            rsp_write_q <= 1'b1;
            rsp_valid_q <= 1'b1;
          end
        end
        RD_REQ: begin
          if (m_arready) begin
            state_q   <= RD_DATA;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
          end
        end
        RD_DATA: begin
          if (m_rvalid && rready_q) begin
            state_q     <= RSP;
            rready_q    <= 1'b0;
            rsp_rdata_q <= m_rdata;
            rsp_resp_q  <= m_rresp;
            rsp_write_q <= 1'b0;
            rsp_valid_q <= 1'b1;
          end
        end
        RSP: begin
          if (rsp_ready) begin
            state_q     <= IDLE;
            rsp_valid_q <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign m_awaddr  = addr_q;
  assign m_awprot  = PROT_DEFAULT;
  assign m_awvalid = awvalid_q;
  assign m_wdata   = wdata_q;
  assign m_wstrb   = wstrb_q;
  assign m_wvalid  = wvalid_q;
  assign m_bready  = bready_q;
  assign m_araddr  = addr_q;
  assign m_arprot  = PROT_DEFAULT;
  assign m_arvalid = arvalid_q;
  assign m_rready  = rready_q;

  assign rsp_valid = rsp_valid_q;
  assign rsp_write = rsp_write_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_resp  = rsp_resp_q;

endmodule
